// File: rtl/uart_tx_engine_if.sv
// Host-side bundle for the UART transmit engine: write port, CTS gate, serial line and status.
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 Wr_En;
  logic [DATA_BITS-1:0] Wr_Data;
  logic                 CTS;
  logic                 Tx;
  logic                 Full;
  logic                 Empty;
  logic                 Busy;
  logic                 Overflow;
  logic                 Tx_Done;

  modport master (
    output Wr_En, Wr_Data, CTS,
    input  Tx, Full, Empty, Busy, Overflow, Tx_Done
  );

  modport slave (
    input  Wr_En, Wr_Data, CTS,
    output Tx, Full, Empty, Busy, Overflow, Tx_Done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-buffered bytes sent as start, data MSB first, optional even parity, stop bits.
// state  | meaning
// IDLE   | line high, waiting for data and CTS
// START  | start bit (low)
// DATA   | data bits, MSB first
// PARITY | XOR parity of the data bits
// STOP   | stop bit(s); last cycle may chain straight into the next frame
module uart_tx_engine #(
  parameter int SYSCLK_RATE = 4,
  parameter int BAUD_RATE   = 1,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input logic               i_SysClk,
  input logic               i_Rst,
  uart_tx_engine_if.slave   io_bus
);

  localparam int BIT_CYCLES = SYSCLK_RATE / BAUD_RATE;
  localparam int BAUD_W     = $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_overflow;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;

  state_t               w_state_nxt;
  logic [BAUD_W-1:0]    w_baud_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_stop_nxt;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_tx;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_baud_wrap;
  logic                 w_can_start;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [DATA_BITS-1:0] w_head;

  // Full is the registered view of the count, so a write on a full cycle is refused even if a pop frees a slot.
  assign w_push      = io_bus.Wr_En && !r_full;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_wrap = (r_baud_cnt == BAUD_W'(BIT_CYCLES - 1));
  assign w_can_start = !r_empty && io_bus.CTS;

  always_ff @(posedge i_SysClk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.Wr_Data;
    end
  end

  always_ff @(posedge i_SysClk) begin
    if (!i_Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= io_bus.Wr_En && r_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_SysClk) begin
    if (!i_Rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_stop_cnt <= w_stop_nxt;
      if (w_pop) begin
        r_shift  <= w_head;
        r_parity <= ^w_head;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_wrap ? '0 : r_baud_cnt + BAUD_W'(1);
    w_idx_nxt   = r_bit_idx;
    w_stop_nxt  = r_stop_cnt;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy     = 1'b0;
        w_baud_nxt = '0;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_wrap) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = IDX_W'(DATA_BITS - 1);
        end
      end
      S_DATA: begin
        w_tx = r_shift[r_bit_idx];
        if (w_baud_wrap) begin
          if (r_bit_idx == '0) begin
            w_state_nxt = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
            w_stop_nxt  = 1'b0;
          end else begin
            w_idx_nxt = r_bit_idx - IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        w_tx = r_parity;
        if (w_baud_wrap) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_baud_wrap) begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_done     = 1'b1;
            w_stop_nxt = 1'b0;
            // Chaining straight into START keeps back-to-back frames gapless.
            if (w_can_start) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_stop_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign io_bus.Tx       = w_tx;
  assign io_bus.Full     = r_full;
  assign io_bus.Empty    = r_empty;
  assign io_bus.Busy     = w_busy;
  assign io_bus.Overflow = r_overflow;
  assign io_bus.Tx_Done  = w_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed plus randomized bench for uart_tx_engine; frames are predicted from byte values alone.
module tb_uart_tx_engine;

  localparam int BITC = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] q_model [$];

  uart_tx_engine_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_engine_if #(.DATA_BITS(8)) bus_b ();

  uart_tx_engine u_dut_a (
    .i_SysClk (clk),
    .i_Rst    (rst),
    .io_bus   (bus_a)
  );

  uart_tx_engine #(.PARITY_BIT(0), .STOP_BITS(1)) u_dut_b (
    .i_SysClk (clk),
    .i_Rst    (rst),
    .io_bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? bus_a.Tx : bus_b.Tx;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus_a.Busy : bus_b.Busy;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? bus_a.Tx_Done : bus_b.Tx_Done;
  endfunction

  // Line level for bit slot pos of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int pos, input int par_en);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[8-pos];
    if (par_en != 0 && pos == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic set_cts(input int sel, input logic v);
    if (sel == 0) bus_a.CTS = v;
    else          bus_b.CTS = v;
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      bus_a.Wr_En = 1'b1; bus_a.Wr_Data = d;
    end else begin
      bus_b.Wr_En = 1'b1; bus_b.Wr_Data = d;
    end
    @(negedge clk);
    bus_a.Wr_En = 1'b0;
    bus_b.Wr_En = 1'b0;
  endtask

  // Call from the negedge just before the frame's first start-bit cycle.
  task automatic run_frame(input int sel, input logic [7:0] d, input int par_en,
                           input int stop_n, input int drop_at);
    int len;
    len = (1 + 8 + par_en + stop_n) * BITC;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk($sformatf("tx_%02h_c%0d", d, c), tx_of(sel), exp_bit(d, (c - 1) / BITC, par_en));
      chk($sformatf("busy_%02h_c%0d", d, c), busy_of(sel), 1'b1);
      chk($sformatf("done_%02h_c%0d", d, c), done_of(sel), (c == len));
      if (c == drop_at) set_cts(sel, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus_a.Wr_En = 1'b0; bus_a.Wr_Data = '0; bus_a.CTS = 1'b1;
    bus_b.Wr_En = 1'b0; bus_b.Wr_Data = '0; bus_b.CTS = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_tx",   bus_a.Tx, 1'b1);
    chk("rst_full", bus_a.Full, 1'b0);
    chk("rst_empty", bus_a.Empty, 1'b1);
    chk("rst_busy", bus_a.Busy, 1'b0);
    chk("rst_ovf",  bus_a.Overflow, 1'b0);
    chk("rst_done", bus_a.Tx_Done, 1'b0);
    chk("rst_b_tx", bus_b.Tx, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Single frame 0xBB, start bit two edges after the write.
    push(0, 8'hBB);
    chk("bb_empty_after_wr", bus_a.Empty, 1'b0);
    chk("bb_tx_still_idle", bus_a.Tx, 1'b1);
    run_frame(0, 8'hBB, 1, 2, 0);
    @(negedge clk);
    chk("bb_busy_after", bus_a.Busy, 1'b0);
    chk("bb_empty_after", bus_a.Empty, 1'b1);
    chk("bb_tx_after", bus_a.Tx, 1'b1);

    // CTS held low: bytes wait, then leave back-to-back.
    bus_a.CTS = 1'b0;
    push(0, 8'hAA);
    push(0, 8'h55);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("cts0_tx_%0d", i), bus_a.Tx, 1'b1);
    end
    chk("cts0_empty", bus_a.Empty, 1'b0);
    chk("cts0_busy", bus_a.Busy, 1'b0);
    bus_a.CTS = 1'b1;
    run_frame(0, 8'hAA, 1, 2, 0);
    run_frame(0, 8'h55, 1, 2, 0);
    @(negedge clk);
    chk("b2b_empty", bus_a.Empty, 1'b1);
    chk("b2b_busy", bus_a.Busy, 1'b0);

    // Fill with random bytes, overflow once, drain in order.
    bus_a.CTS = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      q_model.push_back(d);
      push(0, d);
      if (i == 6) chk("fill_not_full_7", bus_a.Full, 1'b0);
    end
    chk("fill_full", bus_a.Full, 1'b1);
    chk("fill_empty", bus_a.Empty, 1'b0);
    chk("fill_ovf_idle", bus_a.Overflow, 1'b0);
    push(0, 8'hEE);
    chk("ovf_pulse", bus_a.Overflow, 1'b1);
    chk("ovf_full", bus_a.Full, 1'b1);
    @(negedge clk);
    chk("ovf_one_cycle", bus_a.Overflow, 1'b0);
    bus_a.CTS = 1'b1;
    while (q_model.size() > 0) begin
      d = q_model.pop_front();
      run_frame(0, d, 1, 2, 0);
    end
    @(negedge clk);
    chk("drain_empty", bus_a.Empty, 1'b1);
    chk("drain_busy", bus_a.Busy, 1'b0);
    chk("drain_full", bus_a.Full, 1'b0);

    // CTS dropped during data bits: frame completes, next one waits.
    bus_a.CTS = 1'b0;
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    push(0, d);
    push(0, d2);
    bus_a.CTS = 1'b1;
    run_frame(0, d, 1, 2, 12);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("hold_tx_%0d", i), bus_a.Tx, 1'b1);
      chk($sformatf("hold_busy_%0d", i), bus_a.Busy, 1'b0);
    end
    chk("hold_empty", bus_a.Empty, 1'b0);
    bus_a.CTS = 1'b1;
    run_frame(0, d2, 1, 2, 0);
    @(negedge clk);
    chk("hold_drained", bus_a.Empty, 1'b1);

    // No parity, one stop bit: 10-bit, 40-cycle frames.
    push(1, 8'h01);
    run_frame(1, 8'h01, 0, 1, 0);
    d = 8'($urandom_range(0, 255));
    @(negedge clk);
    push(1, d);
    run_frame(1, d, 0, 1, 0);
    @(negedge clk);
    chk("b_busy_after", bus_b.Busy, 1'b0);
    chk("b_empty_after", bus_b.Empty, 1'b1);

    // Reset mid-frame aborts and clears the queue.
    d  = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    push(0, d);
    push(0, d2);
    repeat (20) @(negedge clk);
    chk("mid_busy_pre", bus_a.Busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_tx", bus_a.Tx, 1'b1);
    chk("mid_rst_busy", bus_a.Busy, 1'b0);
    chk("mid_rst_empty", bus_a.Empty, 1'b1);
    chk("mid_rst_full", bus_a.Full, 1'b0);
    @(negedge clk);
    push(0, 8'h3C);
    run_frame(0, 8'h3C, 1, 2, 0);
    @(negedge clk);
    chk("post_rst_busy", bus_a.Busy, 1'b0);
    chk("post_rst_empty", bus_a.Empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
